player_sprite_compositor: RTL

Renders up to NUM_PLAYERS chef sprites onto the VGA scan.
- Per pixel: hit-tests every player box, selects one player by priority, forms a single sprite-ROM address (state, direction, animation frame, offset), then maps the 8-bit colour index through an external palette ROM to 12-bit RGB.
- Player pose and position are latched once per video frame to prevent tearing.
- Animated states (chopping, extinguisher on) cycle frames on a frame-count timer.
- Sits between the game-state logic and the VGA pixel mux.

---
 rtl/player_sprite_compositor.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/player_sprite_compositor.sv
// Per-pixel chef sprite renderer: frame-latched player boxes, priority hit test,
// sprite ROM then palette ROM lookup, with a fixed 4-cycle pixel latency.
module player_sprite_compositor #(
  parameter int          NUM_PLAYERS     = 2,
  parameter int          WIDTH           = 32,
  parameter int          HEIGHT          = 32,
  parameter int          NUM_STATES      = 10,
  parameter int          ANIM_FRAMES     = 2,
  parameter int          ANIM_PERIOD     = 8,
  parameter logic [15:0] ANIM_MASK       = 16'h0202,
  parameter logic [7:0]  TRANSPARENT_IDX = 8'h00,
  parameter int          AW              = $clog2(NUM_STATES*4*ANIM_FRAMES*WIDTH*HEIGHT)
) (
  input  logic                      pixel_clk_in,
  input  logic                      rst_n_in,
  input  logic [10:0]               hcount_in,
  input  logic [9:0]                vcount_in,
  input  logic                      frame_start_in,
  input  logic [11*NUM_PLAYERS-1:0] x_in,
  input  logic [10*NUM_PLAYERS-1:0] y_in,
  input  logic [2*NUM_PLAYERS-1:0]  player_direction,
  input  logic [4*NUM_PLAYERS-1:0]  player_state,
  output logic [AW-1:0]             sprite_addr_out,
  input  logic [7:0]                sprite_data_in,
  output logic [7:0]                palette_addr_out,
  input  logic [23:0]               palette_data_in,
  output logic [11:0]               pixel_out,
  output logic                      hit_out
);

  localparam int FW = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
  localparam int DW = (ANIM_PERIOD > 1) ? $clog2(ANIM_PERIOD) : 1;

  logic                 armed_q;
  logic [NUM_PLAYERS-1:0] hit;
  logic [AW-1:0]        cand [NUM_PLAYERS];

  // Each player keeps its own shadow copy of pose/position plus animation timer.
  for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_player
    logic [10:0]   x_q;
    logic [9:0]    y_q;
    logic [1:0]    dir_q;
    logic [3:0]    state_q;
    logic [3:0]    state_new;
    logic [FW-1:0] frame_q, frame_d;
    logic [DW-1:0] div_q, div_d;
    logic [11:0]   h_ext, x_ext;
    logic [10:0]   v_ext, y_ext;
    logic [10:0]   col;
    logic [9:0]    row;

    assign state_new = (int'(player_state[4*gi +: 4]) >= NUM_STATES) ? 4'd0
                                                                      : player_state[4*gi +: 4];

    always_comb begin
      frame_d = frame_q;
      div_d   = div_q;
      if (state_new != state_q || !ANIM_MASK[state_new]) begin
        frame_d = '0;
        div_d   = '0;
      end else if (div_q == DW'(ANIM_PERIOD - 1)) begin
        div_d   = '0;
        frame_d = (ANIM_FRAMES == 1) ? '0 : frame_q + FW'(1);
      end else begin
        div_d   = div_q + DW'(1);
      end
    end

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
        x_q     <= '0;
        y_q     <= '0;
        dir_q   <= '0;
        state_q <= '0;
        frame_q <= '0;
        div_q   <= '0;
      end else if (frame_start_in) begin
        x_q     <= x_in[11*gi +: 11];
        y_q     <= y_in[10*gi +: 10];
        dir_q   <= player_direction[2*gi +: 2];
        state_q <= state_new;
        frame_q <= frame_d;
        div_q   <= div_d;
      end
    end

    // One extra bit on each side keeps boxes near the screen edge from wrapping.
    assign h_ext = {1'b0, hcount_in};
    assign x_ext = {1'b0, x_q};
    assign v_ext = {1'b0, vcount_in};
    assign y_ext = {1'b0, y_q};

    assign hit[gi] = armed_q
                  && (h_ext >= x_ext) && (h_ext < x_ext + 12'(WIDTH))
                  && (v_ext >= y_ext) && (v_ext < y_ext + 11'(HEIGHT));

    assign col = hcount_in - x_q;
    assign row = vcount_in - y_q;

    assign cand[gi] = AW'((((32'(state_q) * 4 + 32'(dir_q)) * ANIM_FRAMES + 32'(frame_q))
                           * HEIGHT + 32'(row)) * WIDTH + 32'(col));
  end

  logic          any_hit;
  logic [AW-1:0] sel_addr;

  // Scan from the top index down so the lowest-index hit has the final say.
  always_comb begin
    any_hit  = 1'b0;
    sel_addr = '0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        any_hit  = 1'b1;
        sel_addr = cand[i];
      end
    end
  end

  logic [AW-1:0] sprite_addr_q, sprite_addr_d;
  logic          valid_s1_q, valid_s2_q, opaque_s3_q, opaque_s3_d;
  logic [11:0]   pixel_q, pixel_d;
  logic          hit_q;
  logic          armed_d;

  always_comb begin
    armed_d       = armed_q | frame_start_in;
    sprite_addr_d = any_hit ? sel_addr : sprite_addr_q;
    opaque_s3_d   = valid_s2_q && (sprite_data_in != TRANSPARENT_IDX);
    pixel_d       = opaque_s3_q ? {palette_data_in[23:20], palette_data_in[15:12], palette_data_in[7:4]}
                                : 12'h000;
  end

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      armed_q       <= 1'b0;
      sprite_addr_q <= '0;
      valid_s1_q    <= 1'b0;
      valid_s2_q    <= 1'b0;
      opaque_s3_q   <= 1'b0;
      pixel_q       <= '0;
      hit_q         <= 1'b0;
    end else begin
      armed_q       <= armed_d;
      sprite_addr_q <= sprite_addr_d;
      valid_s1_q    <= any_hit;
      valid_s2_q    <= valid_s1_q;
      opaque_s3_q   <= opaque_s3_d;
      pixel_q       <= pixel_d;
      hit_q         <= opaque_s3_q;
    end
  end

  logic palette_unused;
  assign palette_unused = ^{palette_data_in[19:16], palette_data_in[11:8], palette_data_in[3:0]};

  assign sprite_addr_out  = sprite_addr_q;
  assign palette_addr_out = sprite_data_in;
  assign pixel_out        = pixel_q;
  assign hit_out          = hit_q;

endmodule
